// File: rtl/ocu_pool_linebuf.sv
// 2x2 stride-2 signed max pooling over a row-major ternary pixel stream, using a
// one-row line buffer. Optional fill-count port usage_o is enabled by CUTIE_POOL_USAGE_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// IDLE     | waiting for start_i; line buffer flushed
// EVEN_ROW | first row of a pooling pair; horizontal maxima pushed to FIFO
// ODD_ROW  | second row; FIFO head combined with horizontal max into output
// DRAIN    | frame consumed; done_o pulses once the output register empties
module ocu_pool_linebuf #(
    parameter int POOLING_FIFODEPTH = 24,
    parameter int USAGEWIDTH        = 5,
    parameter int DATAWIDTH         = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [5:0]           imagewidth_i,
    input  logic [5:0]           imageheight_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DATAWIDTH-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DATAWIDTH-1:0] out_data_o,
    output logic                 done_o
`ifdef CUTIE_POOL_USAGE_EN
    ,
    output logic [USAGEWIDTH-1:0] usage_o
`endif
);

    typedef enum logic [1:0] {IDLE, EVEN_ROW, ODD_ROW, DRAIN} state_t;

    localparam logic [USAGEWIDTH-1:0] LAST_IDX = USAGEWIDTH'(POOLING_FIFODEPTH - 1);

    state_t                 state_q, state_d;
    logic [5:0]             col_q, row_q, width_q;
    logic [DATAWIDTH-1:0]   held_q;
    logic [USAGEWIDTH-1:0]  wr_ptr_q, rd_ptr_q;
    logic [DATAWIDTH-1:0]   fifo_mem [POOLING_FIFODEPTH];
    logic                   out_valid_q;
    logic [DATAWIDTH-1:0]   out_data_q;

    logic                   fire, col_last, odd_col, last_row, bad_cfg;
    logic                   push, pop, flush;
    logic [DATAWIDTH-1:0]   hmax, head, vmax;

    function automatic logic [DATAWIDTH-1:0] smax(input logic [DATAWIDTH-1:0] a,
                                                  input logic [DATAWIDTH-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    assign fire     = in_valid_i & in_ready_o;
    assign col_last = (col_q == width_q - 6'd1);
    assign odd_col  = col_q[0];
    assign last_row = (row_q == 6'd0);
    assign bad_cfg  = ({1'b0, imagewidth_i} > 7'(2 * POOLING_FIFODEPTH)) ||
                      (imagewidth_i < 6'd2) || (imageheight_i < 6'd2);

    assign hmax = smax(held_q, in_data_i);
    assign head = fifo_mem[rd_ptr_q];
    assign vmax = smax(head, hmax);

    // The last row of an odd-height frame is consumed without filling the buffer.
    assign push  = fire && (state_q == EVEN_ROW) && odd_col && !last_row;
    assign pop   = fire && (state_q == ODD_ROW) && odd_col;
    assign flush = (state_q != IDLE) && (state_d == IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start_i) state_d = bad_cfg ? DRAIN : EVEN_ROW;
            EVEN_ROW: if (fire && col_last) state_d = last_row ? DRAIN : ODD_ROW;
            ODD_ROW:  if (fire && col_last) state_d = last_row ? DRAIN : EVEN_ROW;
            DRAIN:    if (!out_valid_q) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            EVEN_ROW: in_ready_o = 1'b1;
            // Only the pixel that produces a result waits for the output register.
            ODD_ROW:  in_ready_o = !odd_col || !out_valid_q || out_ready_i;
            DRAIN:    done_o     = !out_valid_q;
            default:  ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q   <= '0;
            row_q   <= '0;
            width_q <= '0;
            held_q  <= '0;
        end else if (state_q == IDLE && start_i) begin
            col_q   <= '0;
            row_q   <= imageheight_i - 6'd1;
            width_q <= imagewidth_i;
        end else if (fire) begin
            col_q <= col_last ? 6'd0 : col_q + 6'd1;
            if (col_last && !last_row) row_q <= row_q - 6'd1;
            if (!odd_col) held_q <= in_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= hmax;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (pop) begin
            out_valid_q <= 1'b1;
            out_data_q  <= vmax;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

`ifdef CUTIE_POOL_USAGE_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      usage_o <= '0;
        else if (flush) usage_o <= '0;
        else if (push)  usage_o <= usage_o + 1'b1;
        else if (pop)   usage_o <= usage_o - 1'b1;
    end
`endif

endmodule

// File: tb/tb_ocu_pool_linebuf.sv
// Directed bench for ocu_pool_linebuf: expected pooled values are queued when a frame
// is driven and compared as the DUT emits them.
module tb_ocu_pool_linebuf;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_i = 1'b0;
    logic [5:0] imagewidth_i = '0;
    logic [5:0] imageheight_i = '0;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic [1:0] in_data_i = '0;
    logic       out_valid_o;
    logic       out_ready_i = 1'b1;
    logic [1:0] out_data_o;
    logic       done_o;
`ifdef CUTIE_POOL_USAGE_EN
    logic [4:0] usage_o;
    int         usage_peak = 0;
`endif

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];
    logic signed [1:0] pix [0:7][0:47];
    int wait_cnt [0:383];

    ocu_pool_linebuf dut (
        .clk_i(clk), .rst_i(rst), .start_i(start_i),
        .imagewidth_i(imagewidth_i), .imageheight_i(imageheight_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .done_o(done_o)
`ifdef CUTIE_POOL_USAGE_EN
        , .usage_o(usage_o)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard: every output handshake pops one expected value.
    always @(negedge clk) begin
        logic [1:0] e;
        if (out_valid_o && out_ready_i) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_output observed=%0d required=none", out_data_o);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                assert (out_data_o === e) else begin
                    errors++;
                    $error("FAIL out_data observed=%0d required=%0d", out_data_o, e);
                end
            end
        end
`ifdef CUTIE_POOL_USAGE_EN
        if (int'(usage_o) > usage_peak) usage_peak = int'(usage_o);
`endif
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0d required=%0d", tag, obs, req);
        end
    endtask

    task automatic push_expected(input int w, input int h);
        logic signed [1:0] m;
        for (int r = 0; r + 1 < h; r += 2)
            for (int c = 0; c + 1 < w; c += 2) begin
                m = pix[r][c];
                if (pix[r][c+1] > m)   m = pix[r][c+1];
                if (pix[r+1][c] > m)   m = pix[r+1][c];
                if (pix[r+1][c+1] > m) m = pix[r+1][c+1];
                exp_q.push_back(m);
            end
    endtask

    task automatic random_frame(input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                pix[r][c] = 2'(int'($urandom_range(2)) - 1);
    endtask

    task automatic do_start(input int w, input int h);
        @(posedge clk); #1;
        start_i = 1'b1;
        imagewidth_i = 6'(w);
        imageheight_i = 6'(h);
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic send_pixel(input logic [1:0] d, output int waited);
        int  n = 0;
        bit  ok = 1'b0;
        in_valid_i = 1'b1;
        in_data_i = d;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (in_ready_o) ok = 1'b1;
            else n++;
        end
        check("in_handshake", int'(ok), 1);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        waited = n;
    endtask

    task automatic send_rows(input int w, input int r0, input int r1);
        for (int r = r0; r < r1; r++)
            for (int c = 0; c < w; c++)
                send_pixel(pix[r][c], wait_cnt[r*w+c]);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
            else n++;
        end
        check({tag, "_done"}, int'(seen), 1);
        check({tag, "_left"}, exp_q.size(), 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, int'(done_o), 0);
    endtask

    initial begin
        int dummy;
        int seen;
        #1 rst = 1'b1;
        #2;
        check("rst_out_valid", int'(out_valid_o), 0);
        check("rst_in_ready", int'(in_ready_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_out_data", int'(out_data_o), 0);
`ifdef CUTIE_POOL_USAGE_EN
        check("rst_usage", int'(usage_o), 0);
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 4x4 reference frame: pooled 1,0,-1,1
        pix[0][0:3] = '{2'sd1, 2'sd0, -2'sd1, -2'sd1};
        pix[1][0:3] = '{2'sd0, 2'sd0, -2'sd1, 2'sd0};
        pix[2][0:3] = '{-2'sd1, -2'sd1, 2'sd1, 2'sd0};
        pix[3][0:3] = '{-2'sd1, -2'sd1, 2'sd0, -2'sd1};
        exp_q.push_back(2'b01); exp_q.push_back(2'b00);
        exp_q.push_back(2'b11); exp_q.push_back(2'b01);
        do_start(4, 4);
        send_rows(4, 0, 4);
        wait_done("f4x4");

        // full-width 48x2, single +1 in the last pixel
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 48; c++) pix[r][c] = -2'sd1;
        pix[1][47] = 2'sd1;
        push_expected(48, 2);
`ifdef CUTIE_POOL_USAGE_EN
        usage_peak = 0;
`endif
        do_start(48, 2);
        send_rows(48, 0, 2);
        wait_done("f48x2");
`ifdef CUTIE_POOL_USAGE_EN
        check("usage_peak", usage_peak, 24);
        check("usage_end", int'(usage_o), 0);
`endif

        // 5x3 odd dims; a start pulse mid-frame must be ignored
        random_frame(5, 3);
        push_expected(5, 3);
        do_start(5, 3);
        send_rows(5, 0, 1);
        do_start(50, 2);
        send_rows(5, 1, 3);
        wait_done("f5x3");

        // 4x2 with output back-pressure for 10 cycles
        random_frame(4, 2);
        push_expected(4, 2);
        do_start(4, 2);
        fork
            begin
                out_ready_i = 1'b0;
                repeat (10) @(posedge clk);
                #1 out_ready_i = 1'b1;
            end
            send_rows(4, 0, 2);
        join
        check("stall_first_odd", wait_cnt[5], 0);
        check("stall_second_odd", int'(wait_cnt[7] > 0), 1);
        wait_done("f4x2");

        // reset after 6 pixels of an 8x8 frame
        random_frame(8, 8);
        do_start(8, 8);
        for (int i = 0; i < 6; i++) send_pixel(pix[0][i], dummy);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid_o), 0);
        check("midrst_in_ready", int'(in_ready_o), 0);
        check("midrst_done", int'(done_o), 0);
        check("midrst_out_data", int'(out_data_o), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_o) seen++;
        end
        check("midrst_no_done", seen, 0);
        random_frame(4, 4);
        push_expected(4, 4);
        do_start(4, 4);
        send_rows(4, 0, 4);
        wait_done("f4x4_after_rst");

        // degenerate configurations finish at once with no output
        begin
            int cfg [3][2] = '{'{50, 4}, '{1, 4}, '{4, 1}};
            for (int k = 0; k < 3; k++) begin
                do_start(cfg[k][0], cfg[k][1]);
                @(negedge clk);
                check("bad_cfg_done", int'(done_o), 1);
                check("bad_cfg_valid", int'(out_valid_o), 0);
                @(negedge clk);
                check("bad_cfg_done_pulse", int'(done_o), 0);
            end
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
